edge_period_monitor: RTL and testbench

EDGE_PERIOD_MONITOR -- requirements
Module: edge_period_monitor

---
 rtl/edge_period_monitor.sv | 135 +++++++++++++
 tb/tb_edge_period_monitor.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_period_monitor.sv
// Measures rising-edge-to-rising-edge intervals of an asynchronous clock in
// units of clk cycles, reporting last/min/max/sum and a sticky saturation flag.
module edge_period_monitor #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   ck_in,
  input  logic                   start,
  input  logic [NUM_W-1:0]       num_edges,
  output logic                   busy,
  output logic                   done,
  output logic [CNT_W-1:0]       period_last,
  output logic [CNT_W-1:0]       period_min,
  output logic [CNT_W-1:0]       period_max,
  output logic [CNT_W+NUM_W-1:0] period_sum,
  output logic                   overflow
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_e;

  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_SAT - 1'b1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e                   state_q, state_d;
  logic                     sync1_q, sync2_q, sync3_q;
  logic                     rise_det;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [NUM_W-1:0]         icnt_q, icnt_d, icnt_inc;
  logic [NUM_W-1:0]         num_q, num_d;
  logic [CNT_W-1:0]         last_q, last_d, min_q, min_d, max_q, max_d;
  logic [CNT_W+NUM_W-1:0]   sum_q, sum_d;
  logic                     ovf_q, ovf_d;

  // Two-flop synchronizer plus an edge register for ck_in.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= ck_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rise_det = sync2_q & ~sync3_q;
  assign icnt_inc = icnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    icnt_d  = icnt_q;
    num_d   = num_q;
    last_d  = last_q;
    min_d   = min_q;
    max_d   = max_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          num_d   = num_edges;
          last_d  = '0;
          min_d   = CNT_SAT;
          max_d   = '0;
          sum_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = (num_edges != '0) ? ARM : DONE;
        end
      end
      ARM: begin
        // The first edge only aligns the counter; no interval has elapsed yet.
        if (rise_det) begin
          state_d = MEAS;
          cnt_d   = CNT_ONE;
          icnt_d  = '0;
        end
      end
      MEAS: begin
        if (rise_det) begin
          last_d = cnt_q;
          if (cnt_q < min_q) min_d = cnt_q;
          if (cnt_q > max_q) max_d = cnt_q;
          sum_d  = sum_q + {{NUM_W{1'b0}}, cnt_q};
          icnt_d = icnt_inc;
          cnt_d  = CNT_ONE;
          if (icnt_inc == num_q) state_d = DONE;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_PRE) ovf_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      icnt_q  <= '0;
      num_q   <= '0;
      last_q  <= '0;
      min_q   <= CNT_SAT;
      max_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      icnt_q  <= icnt_d;
      num_q   <= num_d;
      last_q  <= last_d;
      min_q   <= min_d;
      max_q   <= max_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy        = (state_q == ARM) || (state_q == MEAS);
  assign done        = (state_q == DONE);
  assign period_last = last_q;
  assign period_min  = min_q;
  assign period_max  = max_q;
  assign period_sum  = sum_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_edge_period_monitor.sv
// Bench for edge_period_monitor: a default-width instance and a CNT_W=4
// instance share all inputs and are compared against an interval-list model.
module tb_edge_period_monitor;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ck_in = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  num_edges = 8'd0;

  logic        busyB, doneB, ovfB;
  logic [15:0] lastB, minB, maxB;
  logic [23:0] sumB;
  logic        busyS, doneS, ovfS;
  logic [3:0]  lastS, minS, maxS;
  logic [11:0] sumS;

  int checkCount = 0;
  int passCount = 0;
  int doneCount = 0;
  int doneCountS = 0;
  int busySeen = 0;
  int per[$];

  edge_period_monitor #(.CNT_W(16), .NUM_W(8)) dutBig (
    .clk(clk), .rstn(rstn), .ck_in(ck_in), .start(start), .num_edges(num_edges),
    .busy(busyB), .done(doneB), .period_last(lastB), .period_min(minB),
    .period_max(maxB), .period_sum(sumB), .overflow(ovfB)
  );

  edge_period_monitor #(.CNT_W(4), .NUM_W(8)) dutSmall (
    .clk(clk), .rstn(rstn), .ck_in(ck_in), .start(start), .num_edges(num_edges),
    .busy(busyS), .done(doneS), .period_last(lastS), .period_min(minS),
    .period_max(maxS), .period_sum(sumS), .overflow(ovfS)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (doneB) doneCount++;
    if (doneS) doneCountS++;
    if (busyB) busySeen++;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: each interval saturates at 2^w-1; results are plain reductions.
  task automatic model(input int n, input int w, output longint last, output longint mn,
                       output longint mx, output longint sum, output bit ovf);
    longint sat, v;
    sat = (longint'(1) << w) - 1;
    last = 0; mn = sat; mx = 0; sum = 0; ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      v = (per[i] >= sat) ? sat : per[i];
      if (per[i] >= sat) ovf = 1'b1;
      last = v;
      if (v < mn) mn = v;
      if (v > mx) mx = v;
      sum += v;
    end
  endtask

  // Pulses start, then drives n+1 ck_in rises spaced by per[0..n-1].
  task automatic run_measure(input int n, input int restartAt);
    int base, k, hi;
    base = doneCount;
    start = 1'b1;
    num_edges = n[7:0];
    @(negedge clk);
    start = 1'b0;
    num_edges = ~n[7:0];
    if (n > 0) begin
      for (int i = 0; i <= n; i++) begin
        ck_in = 1'b1;
        if (i == restartAt) begin
          start = 1'b1;
          num_edges = 8'd2;
        end
        if (i < n) begin
          hi = per[i] / 2;
          wait_cycles(1);
          start = 1'b0;
          wait_cycles(hi - 1);
          ck_in = 1'b0;
          wait_cycles(per[i] - hi);
        end else begin
          wait_cycles(1);
          start = 1'b0;
          ck_in = 1'b0;
        end
      end
    end
    k = 0;
    while (doneCount == base && k < 60) begin
      @(negedge clk);
      k++;
    end
    checkCount++;
    if (doneCount == base) $display("[TB] FAIL done_timeout: got no done pulse expected one within 60 cycles");
    else passCount++;
    wait_cycles(4);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checkCount++; if (busyB !== 1'b0) $display("[TB] FAIL reset_busy: got %0d expected 0", busyB); else passCount++;
    checkCount++; if (doneB !== 1'b0) $display("[TB] FAIL reset_done: got %0d expected 0", doneB); else passCount++;
    checkCount++; if (ovfB !== 1'b0) $display("[TB] FAIL reset_ovf: got %0d expected 0", ovfB); else passCount++;
    checkCount++; if (lastB !== 16'd0) $display("[TB] FAIL reset_last: got %0d expected 0", lastB); else passCount++;
    checkCount++; if (minB !== 16'hFFFF) $display("[TB] FAIL reset_min: got %0d expected 65535", minB); else passCount++;
    checkCount++; if (maxB !== 16'd0) $display("[TB] FAIL reset_max: got %0d expected 0", maxB); else passCount++;
    checkCount++; if (sumB !== 24'd0) $display("[TB] FAIL reset_sum: got %0d expected 0", sumB); else passCount++;
    checkCount++; if (minS !== 4'hF) $display("[TB] FAIL reset_min_small: got %0d expected 15", minS); else passCount++;
    rstn = 1'b1;
    wait_cycles(2);
  endtask

  task automatic test_basic();
    int b;
    b = doneCount;
    per = '{8, 8, 8, 8};
    run_measure(4, -1);
    checkCount++; if (doneCount - b !== 1) $display("[TB] FAIL basic_done_count: got %0d expected 1", doneCount - b); else passCount++;
    checkCount++; if (lastB !== 16'd8) $display("[TB] FAIL basic_last: got %0d expected 8", lastB); else passCount++;
    checkCount++; if (minB !== 16'd8) $display("[TB] FAIL basic_min: got %0d expected 8", minB); else passCount++;
    checkCount++; if (maxB !== 16'd8) $display("[TB] FAIL basic_max: got %0d expected 8", maxB); else passCount++;
    checkCount++; if (sumB !== 24'd32) $display("[TB] FAIL basic_sum: got %0d expected 32", sumB); else passCount++;
    checkCount++; if (ovfB !== 1'b0) $display("[TB] FAIL basic_ovf: got %0d expected 0", ovfB); else passCount++;
  endtask

  task automatic test_alternating();
    per = '{7, 9, 7, 9, 7, 9};
    run_measure(6, -1);
    checkCount++; if (minB !== 16'd7) $display("[TB] FAIL alt_min: got %0d expected 7", minB); else passCount++;
    checkCount++; if (maxB !== 16'd9) $display("[TB] FAIL alt_max: got %0d expected 9", maxB); else passCount++;
    checkCount++; if (sumB !== 24'd48) $display("[TB] FAIL alt_sum: got %0d expected 48", sumB); else passCount++;
    checkCount++; if (lastB !== 16'd9) $display("[TB] FAIL alt_last: got %0d expected 9", lastB); else passCount++;
  endtask

  task automatic test_zero();
    int b;
    b = busySeen;
    start = 1'b1;
    num_edges = 8'd0;
    @(negedge clk);
    start = 1'b0;
    checkCount++; if (doneB !== 1'b1) $display("[TB] FAIL zero_done: got %0d expected 1", doneB); else passCount++;
    checkCount++; if (sumB !== 24'd0) $display("[TB] FAIL zero_sum: got %0d expected 0", sumB); else passCount++;
    checkCount++; if (minB !== 16'hFFFF) $display("[TB] FAIL zero_min: got %0d expected 65535", minB); else passCount++;
    checkCount++; if (minS !== 4'hF) $display("[TB] FAIL zero_min_small: got %0d expected 15", minS); else passCount++;
    @(negedge clk);
    checkCount++; if (doneB !== 1'b0) $display("[TB] FAIL zero_done_width: got %0d expected 0", doneB); else passCount++;
    wait_cycles(2);
    checkCount++; if (busySeen !== b) $display("[TB] FAIL zero_busy: got %0d busy cycles expected 0", busySeen - b); else passCount++;
  endtask

  task automatic test_overflow();
    per = '{20, 20};
    run_measure(2, -1);
    checkCount++; if (lastS !== 4'd15) $display("[TB] FAIL ovf_last_small: got %0d expected 15", lastS); else passCount++;
    checkCount++; if (ovfS !== 1'b1) $display("[TB] FAIL ovf_flag_small: got %0d expected 1", ovfS); else passCount++;
    checkCount++; if (sumS !== 12'd30) $display("[TB] FAIL ovf_sum_small: got %0d expected 30", sumS); else passCount++;
    checkCount++; if (lastB !== 16'd20) $display("[TB] FAIL ovf_last_big: got %0d expected 20", lastB); else passCount++;
    checkCount++; if (ovfB !== 1'b0) $display("[TB] FAIL ovf_flag_big: got %0d expected 0", ovfB); else passCount++;
  endtask

  task automatic test_restart_ignored();
    int b;
    b = doneCount;
    per = '{6, 6, 6, 6, 6};
    run_measure(5, 2);
    checkCount++; if (doneCount - b !== 1) $display("[TB] FAIL restart_done_count: got %0d expected 1", doneCount - b); else passCount++;
    checkCount++; if (sumB !== 24'd30) $display("[TB] FAIL restart_sum: got %0d expected 30", sumB); else passCount++;
  endtask

  task automatic test_reset_mid();
    int b;
    b = doneCount;
    start = 1'b1;
    num_edges = 8'd4;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 2; j++) begin
      ck_in = 1'b1;
      wait_cycles(5);
      ck_in = 1'b0;
      wait_cycles(5);
    end
    rstn = 1'b0;
    #1;
    checkCount++; if (busyB !== 1'b0) $display("[TB] FAIL rstmid_busy: got %0d expected 0", busyB); else passCount++;
    checkCount++; if (lastB !== 16'd0) $display("[TB] FAIL rstmid_last: got %0d expected 0", lastB); else passCount++;
    checkCount++; if (sumB !== 24'd0) $display("[TB] FAIL rstmid_sum: got %0d expected 0", sumB); else passCount++;
    checkCount++; if (minB !== 16'hFFFF) $display("[TB] FAIL rstmid_min: got %0d expected 65535", minB); else passCount++;
    checkCount++; if (maxB !== 16'd0) $display("[TB] FAIL rstmid_max: got %0d expected 0", maxB); else passCount++;
    wait_cycles(2);
    rstn = 1'b1;
    wait_cycles(10);
    checkCount++; if (doneCount !== b) $display("[TB] FAIL rstmid_no_done: got %0d pulses expected 0", doneCount - b); else passCount++;
    per = '{5, 5, 5};
    run_measure(3, -1);
    checkCount++; if (sumB !== 24'd15) $display("[TB] FAIL rstmid_after_sum: got %0d expected 15", sumB); else passCount++;
    checkCount++; if (lastB !== 16'd5) $display("[TB] FAIL rstmid_after_last: got %0d expected 5", lastB); else passCount++;
  endtask

  task automatic test_hold();
    per = '{12, 12, 12};
    run_measure(3, -1);
    for (int j = 0; j < 4; j++) begin
      ck_in = 1'b1;
      wait_cycles(2);
      ck_in = 1'b0;
      wait_cycles(2);
    end
    wait_cycles(4);
    checkCount++; if (lastB !== 16'd12) $display("[TB] FAIL hold_last: got %0d expected 12", lastB); else passCount++;
    checkCount++; if (sumB !== 24'd36) $display("[TB] FAIL hold_sum: got %0d expected 36", sumB); else passCount++;
    checkCount++; if (busyB !== 1'b0) $display("[TB] FAIL hold_busy: got %0d expected 0", busyB); else passCount++;
  endtask

  task automatic test_random();
    int n, b, bs;
    longint eLast, eMin, eMax, eSum, sLast, sMin, sMax, sSum;
    bit eOvf, sOvf;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 8);
      per.delete();
      for (int i = 0; i < n; i++) per.push_back($urandom_range(2, 24));
      b = doneCount;
      bs = doneCountS;
      run_measure(n, -1);
      model(n, 16, eLast, eMin, eMax, eSum, eOvf);
      model(n, 4, sLast, sMin, sMax, sSum, sOvf);
      checkCount++; if (lastB !== eLast[15:0]) $display("[TB] FAIL rand_last: got %0d expected %0d", lastB, eLast); else passCount++;
      checkCount++; if (minB !== eMin[15:0]) $display("[TB] FAIL rand_min: got %0d expected %0d", minB, eMin); else passCount++;
      checkCount++; if (maxB !== eMax[15:0]) $display("[TB] FAIL rand_max: got %0d expected %0d", maxB, eMax); else passCount++;
      checkCount++; if (sumB !== eSum[23:0]) $display("[TB] FAIL rand_sum: got %0d expected %0d", sumB, eSum); else passCount++;
      checkCount++; if (ovfB !== eOvf) $display("[TB] FAIL rand_ovf: got %0d expected %0d", ovfB, eOvf); else passCount++;
      checkCount++; if (lastS !== sLast[3:0]) $display("[TB] FAIL rand_last_small: got %0d expected %0d", lastS, sLast); else passCount++;
      checkCount++; if (minS !== sMin[3:0]) $display("[TB] FAIL rand_min_small: got %0d expected %0d", minS, sMin); else passCount++;
      checkCount++; if (maxS !== sMax[3:0]) $display("[TB] FAIL rand_max_small: got %0d expected %0d", maxS, sMax); else passCount++;
      checkCount++; if (sumS !== sSum[11:0]) $display("[TB] FAIL rand_sum_small: got %0d expected %0d", sumS, sSum); else passCount++;
      checkCount++; if (ovfS !== sOvf) $display("[TB] FAIL rand_ovf_small: got %0d expected %0d", ovfS, sOvf); else passCount++;
      checkCount++; if (doneCount - b !== 1) $display("[TB] FAIL rand_done_count: got %0d expected 1", doneCount - b); else passCount++;
      checkCount++; if (doneCountS - bs !== 1) $display("[TB] FAIL rand_done_count_small: got %0d expected 1", doneCountS - bs); else passCount++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alternating();
    test_zero();
    test_overflow();
    test_restart_ignored();
    test_reset_mid();
    test_hold();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
